ysyx_25040111_axi_sram: RTL and testbench

- AXI4 single-beat slave (responder) modelling on-chip SRAM; the far end of the LSU/IFU master ports (io_master_*).
- Accepts one outstanding read or write at a time, inserts a configurable access latency, applies byte strobes, and returns OKAY/SLVERR/DECERR responses.
- Sits behind the crossbar in simulation and SoC-less builds as the default memory target.

---
 rtl/ysyx_25040111_axi_sram.sv | 153 +++++++++++++++
 tb/tb_ysyx_25040111_axi_sram.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25040111_axi_sram.sv
// AXI4 single-beat SRAM responder: one outstanding transaction, a fixed
// access latency, byte-strobed writes, and OKAY/SLVERR/DECERR responses.
module ysyx_25040111_axi_sram #(
  parameter logic [31:0] BASE    = 32'h8000_0000,
  parameter int          DEPTH   = 1024,
  parameter int          LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] awaddr,
  input  logic [3:0]  awid,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic        wvalid,
  output logic        wready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  output logic        bvalid,
  input  logic        bready,
  output logic [1:0]  bresp,
  output logic [3:0]  bid,
  input  logic        arvalid,
  output logic        arready,
  input  logic [31:0] araddr,
  input  logic [3:0]  arid,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  output logic        rvalid,
  input  logic        rready,
  output logic [1:0]  rresp,
  output logic [31:0] rdata,
  output logic        rlast,
  output logic [3:0]  rid
);

  localparam int              AW     = $clog2(DEPTH);
  localparam int              CW     = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);
  localparam logic [CW-1:0]   LAT_LD = CW'(LATENCY);
  localparam logic [32:0]     SPAN   = 33'(4 * DEPTH);

  typedef enum logic [2:0] {
    IDLE, RD_WAIT, RD_RESP, WR_DATA, WR_WAIT, WR_RESP
  } state_t;

  state_t        state, state_nxt;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] idx_q;
  logic [1:0]    err_q;
  logic [CW-1:0] cnt_q;
  logic [32:0]   ar_off, aw_off;
  logic          ar_fire, aw_fire, w_fire;

  // Burst type and wlast carry no information for a single-beat slave.
  logic unused_ok;
  assign unused_ok = ^{awburst, arburst, wlast};

  // Response code fixed at address acceptance: decode range first, then shape.
  function automatic logic [1:0] decode_err(input logic [32:0] off,
                                            input logic [7:0]  len,
                                            input logic [2:0]  size);
    if (off >= SPAN)                          return 2'b11;
    else if (len != 8'd0 || size > 3'd2)      return 2'b10;
    else                                      return 2'b00;
  endfunction

  // Offsets are 33 bits so an address below BASE wraps to a huge value
  // and falls outside the window instead of aliasing into it.
  assign ar_off  = {1'b0, araddr} - {1'b0, BASE};
  assign aw_off  = {1'b0, awaddr} - {1'b0, BASE};
  assign ar_fire = (state == IDLE) && arvalid && arready;
  assign aw_fire = (state == IDLE) && !ar_fire && awvalid && awready;
  assign w_fire  = (state == WR_DATA) && wvalid && wready;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; reads win over writes when both arrive in IDLE.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (ar_fire) state_nxt = RD_WAIT;
               else if (aw_fire) state_nxt = WR_DATA;
      RD_WAIT: if (cnt_q == '0) state_nxt = RD_RESP;
      RD_RESP: if (rready) state_nxt = IDLE;
      WR_DATA: if (w_fire) state_nxt = WR_WAIT;
      WR_WAIT: if (cnt_q == '0) state_nxt = WR_RESP;
      WR_RESP: if (bready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Response valids follow the state directly.
  always_comb begin
    rvalid = (state == RD_RESP);
    rlast  = (state == RD_RESP);
    bvalid = (state == WR_RESP);
  end

  // Registered readies, transaction context, latency counter and read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arready <= 1'b0;
      awready <= 1'b0;
      wready  <= 1'b0;
      idx_q   <= '0;
      err_q   <= 2'b00;
      cnt_q   <= '0;
      rresp   <= 2'b00;
      rid     <= 4'd0;
      bresp   <= 2'b00;
      bid     <= 4'd0;
      rdata   <= 32'd0;
    end else begin
      arready <= (state_nxt == IDLE);
      awready <= (state_nxt == IDLE);
      wready  <= (state_nxt == WR_DATA);
      if (ar_fire) begin
        idx_q <= ar_off[AW+1:2];
        err_q <= decode_err(ar_off, arlen, arsize);
        rresp <= decode_err(ar_off, arlen, arsize);
        rid   <= arid;
      end else if (aw_fire) begin
        idx_q <= aw_off[AW+1:2];
        err_q <= decode_err(aw_off, awlen, awsize);
        bresp <= decode_err(aw_off, awlen, awsize);
        bid   <= awid;
      end
      if ((state_nxt == RD_WAIT || state_nxt == WR_WAIT) && state_nxt != state)
        cnt_q <= LAT_LD;
      else if (cnt_q != '0)
        cnt_q <= cnt_q - 1'b1;
      if (state == RD_WAIT && state_nxt == RD_RESP)
        rdata <= (err_q == 2'b00) ? mem[idx_q] : 32'd0;
    end
  end

  // Storage array: only OKAY writes touch it, one byte lane per strobe bit.
  always_ff @(posedge clk) begin
    if (w_fire && err_q == 2'b00) begin
      for (int i = 0; i < 4; i++)
        if (wstrb[i]) mem[idx_q][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

endmodule

// File: tb/tb_ysyx_25040111_axi_sram.sv
// Bench for ysyx_25040111_axi_sram: one instance at LATENCY=2, one at
// LATENCY=0, steered by sel; expected responses queued at issue time.
module tb_ysyx_25040111_axi_sram;

  localparam logic [31:0] BASE = 32'h8000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0, rst1, sel;
  logic        arvalid, rready, awvalid, wvalid, wlast, bready;
  logic [31:0] araddr, awaddr, wdata;
  logic [3:0]  arid, awid, wstrb;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst;

  logic        arready_a, awready_a, wready_a, bvalid_a, rvalid_a, rlast_a;
  logic        arready_b, awready_b, wready_b, bvalid_b, rvalid_b, rlast_b;
  logic [1:0]  bresp_a, rresp_a, bresp_b, rresp_b;
  logic [3:0]  bid_a, rid_a, bid_b, rid_b;
  logic [31:0] rdata_a, rdata_b;

  logic        arready, awready, wready, bvalid, rvalid, rlast;
  logic [1:0]  bresp, rresp;
  logic [3:0]  bid, rid;
  logic [31:0] rdata;

  assign arready = sel ? arready_b : arready_a;
  assign awready = sel ? awready_b : awready_a;
  assign wready  = sel ? wready_b  : wready_a;
  assign bvalid  = sel ? bvalid_b  : bvalid_a;
  assign rvalid  = sel ? rvalid_b  : rvalid_a;
  assign rlast   = sel ? rlast_b   : rlast_a;
  assign bresp   = sel ? bresp_b   : bresp_a;
  assign rresp   = sel ? rresp_b   : rresp_a;
  assign bid     = sel ? bid_b     : bid_a;
  assign rid     = sel ? rid_b     : rid_a;
  assign rdata   = sel ? rdata_b   : rdata_a;

  ysyx_25040111_axi_sram #(.BASE(BASE), .DEPTH(1024), .LATENCY(2)) u_lat2 (
    .clk(clk), .rst(rst0),
    .awvalid(awvalid & ~sel), .awready(awready_a), .awaddr(awaddr), .awid(awid),
    .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .wvalid(wvalid & ~sel), .wready(wready_a), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid_a), .bready(bready), .bresp(bresp_a), .bid(bid_a),
    .arvalid(arvalid & ~sel), .arready(arready_a), .araddr(araddr), .arid(arid),
    .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid_a), .rready(rready), .rresp(rresp_a), .rdata(rdata_a),
    .rlast(rlast_a), .rid(rid_a));

  ysyx_25040111_axi_sram #(.BASE(BASE), .DEPTH(1024), .LATENCY(0)) u_lat0 (
    .clk(clk), .rst(rst1),
    .awvalid(awvalid & sel), .awready(awready_b), .awaddr(awaddr), .awid(awid),
    .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .wvalid(wvalid & sel), .wready(wready_b), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid_b), .bready(bready), .bresp(bresp_b), .bid(bid_b),
    .arvalid(arvalid & sel), .arready(arready_b), .araddr(araddr), .arid(arid),
    .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid_b), .rready(rready), .rresp(rresp_b), .rdata(rdata_b),
    .rlast(rlast_b), .rid(rid_b));

  int total = 0;
  int bad   = 0;

  logic [31:0] mdl [2][1024];

  typedef struct packed {
    logic [3:0]  id;
    logic [1:0]  resp;
    logic [31:0] data;
  } exp_t;

  exp_t rq[$];
  exp_t wq[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] exp_err(input logic [31:0] a, input logic [7:0] len,
                                         input logic [2:0] size);
    if (a < BASE || a >= BASE + 32'd4096) return 2'b11;
    if (len != 8'd0 || size > 3'd2)      return 2'b10;
    return 2'b00;
  endfunction

  function automatic int lat();
    return sel ? 0 : 2;
  endfunction

  task automatic wr(input logic [31:0] a, input logic [3:0] id, input logic [31:0] d,
                    input logic [3:0] s, input logic [7:0] len);
    int n;
    exp_t e;
    logic [1:0] er;
    logic [9:0] ix;
    awaddr = a; awid = id; awlen = len; awsize = 3'd2; awvalid = 1'b1;
    n = 0;
    while (!awready && n < 50) begin tick(); n++; end
    chk("aw_wait", 64'(n < 50), 64'd1);
    tick();
    awvalid = 1'b0;
    chk("wready_set", 64'(wready), 64'd1);
    wdata = d; wstrb = s; wlast = 1'b1; wvalid = 1'b1;
    er = exp_err(a, len, 3'd2);
    ix = 10'((a - BASE) >> 2);
    if (er == 2'b00)
      for (int i = 0; i < 4; i++)
        if (s[i]) mdl[sel][ix][8*i +: 8] = d[8*i +: 8];
    wq.push_back('{id, er, 32'h0});
    tick();
    wvalid = 1'b0;
    chk("wready_drop", 64'(wready), 64'd0);
    n = 0;
    do begin tick(); n++; end while (!bvalid && n < 50);
    chk("b_latency", 64'(n), 64'(1 + lat()));
    e = wq.pop_front();
    chk("bid", 64'(bid), 64'(e.id));
    chk("bresp", 64'(bresp), 64'(e.resp));
    bready = 1'b1;
    tick();
    bready = 1'b0;
    chk("bvalid_clr", 64'(bvalid), 64'd0);
  endtask

  task automatic rd(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                    input int hold);
    int n;
    exp_t e;
    logic [1:0] er;
    logic [31:0] d;
    araddr = a; arid = id; arlen = len; arsize = 3'd2; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 50) begin tick(); n++; end
    chk("ar_wait", 64'(n < 50), 64'd1);
    er = exp_err(a, len, 3'd2);
    d  = (er == 2'b00) ? mdl[sel][10'((a - BASE) >> 2)] : 32'd0;
    rq.push_back('{id, er, d});
    tick();
    arvalid = 1'b0;
    n = 0;
    do begin
      tick(); n++;
      chk("awready_blocked", 64'(awready), 64'd0);
    end while (!rvalid && n < 50);
    chk("r_latency", 64'(n), 64'(1 + lat()));
    e = rq.pop_front();
    chk("rid", 64'(rid), 64'(e.id));
    chk("rresp", 64'(rresp), 64'(e.resp));
    chk("rdata", 64'(rdata), 64'(e.data));
    chk("rlast", 64'(rlast), 64'd1);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_rvalid", 64'(rvalid), 64'd1);
      chk("hold_rdata", 64'(rdata), 64'(e.data));
      chk("hold_rid", 64'(rid), 64'(e.id));
      chk("hold_arready", 64'(arready), 64'd0);
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
    chk("rvalid_clr", 64'(rvalid), 64'd0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_arready"}, 64'(arready), 64'd0);
    chk({tag, "_awready"}, 64'(awready), 64'd0);
    chk({tag, "_wready"},  64'(wready),  64'd0);
    chk({tag, "_rvalid"},  64'(rvalid),  64'd0);
    chk({tag, "_bvalid"},  64'(bvalid),  64'd0);
    chk({tag, "_rdata"},   64'(rdata),   64'd0);
    chk({tag, "_rresp"},   64'(rresp),   64'd0);
    chk({tag, "_rid"},     64'(rid),     64'd0);
    chk({tag, "_bresp"},   64'(bresp),   64'd0);
    chk({tag, "_bid"},     64'(bid),     64'd0);
  endtask

  initial begin
    rst0 = 1'b0; rst1 = 1'b0; sel = 1'b0;
    arvalid = 1'b0; rready = 1'b0; awvalid = 1'b0; wvalid = 1'b0; wlast = 1'b0;
    bready = 1'b0; araddr = '0; awaddr = '0; wdata = '0; arid = '0; awid = '0;
    wstrb = '0; arlen = '0; awlen = '0; arsize = 3'd2; awsize = 3'd2;
    arburst = 2'b01; awburst = 2'b01;
    #1;
    rst0 = 1'b1; rst1 = 1'b1;
    repeat (2) tick();
    chk_zero("reset");
    #2;
    rst0 = 1'b0; rst1 = 1'b0;
    chk("arready_pre_edge", 64'(arready), 64'd0);
    tick();
    chk("arready_after_rst", 64'(arready), 64'd1);
    chk("awready_after_rst", 64'(awready), 64'd1);

    // Basic write/read and strobe merge at LATENCY=2
    wr(32'h8000_0010, 4'd1, 32'hDEAD_BEEF, 4'hF, 8'd0);
    rd(32'h8000_0010, 4'd2, 8'd0, 0);
    wr(32'h8000_0010, 4'd1, 32'h0000_5500, 4'b0010, 8'd0);
    rd(32'h8000_0010, 4'd2, 8'd0, 0);

    // Read and write arrive together: read first, write stays pending
    awaddr = 32'h8000_0040; awid = 4'd5; awlen = 8'd0; awsize = 3'd2; awvalid = 1'b1;
    rd(32'h8000_0010, 4'd3, 8'd0, 0);
    chk("awready_after_r", 64'(awready), 64'd1);
    wr(32'h8000_0040, 4'd5, 32'hCAFE_F00D, 4'hF, 8'd0);

    // Backpressure on R for five cycles
    rd(32'h8000_0040, 4'd6, 8'd0, 5);

    // Error responses
    rd(32'h9000_0000, 4'd7, 8'd0, 0);
    rd(32'h8000_0010, 4'd8, 8'd3, 0);
    wr(32'h8000_0FFC, 4'd9, 32'h1234_5678, 4'hF, 8'd0);
    wr(32'h7FFF_FFFC, 4'd10, 32'hFFFF_FFFF, 4'hF, 8'd0);
    rd(32'h8000_0FFC, 4'd11, 8'd0, 0);
    wr(32'h8000_0010, 4'd12, 32'h0000_0000, 4'h0, 8'd0);
    rd(32'h8000_0010, 4'd13, 8'd0, 0);

    // LATENCY=0 instance
    sel = 1'b1;
    wr(32'h8000_0020, 4'd2, 32'hA5A5_5A5A, 4'hF, 8'd0);
    rd(32'h8000_0020, 4'd4, 8'd0, 0);

    // Async reset while a read sits in RD_WAIT
    araddr = 32'h8000_0020; arid = 4'd7; arlen = 8'd0; arvalid = 1'b1;
    chk("rst_ar_ready", 64'(arready), 64'd1);
    tick();
    arvalid = 1'b0;
    #2;
    rst1 = 1'b1;
    #1;
    chk_zero("midrst");
    tick();
    chk("midrst_rvalid_hold", 64'(rvalid), 64'd0);
    #3;
    rst1 = 1'b0;
    chk("midrst_arready_rel", 64'(arready), 64'd0);
    tick();
    chk("midrst_arready_up", 64'(arready), 64'd1);
    for (int i = 0; i < 3; i++) begin
      chk("midrst_no_rvalid", 64'(rvalid), 64'd0);
      tick();
    end
    rd(32'h8000_0020, 4'd1, 8'd0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
